timer_bank: RTL and testbench

//  Parametrised successor to the 3-channel counter peripheral on the 0xf... GPIO/counter bus.

---
 rtl/timer_bank_pkg.sv | 32 +++
 rtl/timer_bank_if.sv | 13 +
 rtl/timer_bank_channel.sv | 88 ++++++++
 rtl/timer_bank.sv | 89 ++++++++
 tb/tb_timer_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: channel modes, register offsets,
// CTRL bit positions and the channel run state.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT      = 2'b00,
        MODE_PERIODIC     = 2'b01,
        MODE_PWM          = 2'b10,
        MODE_PERIODIC_ALT = 2'b11
    } mode_t;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_LOAD = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_PEND     = 8;

    // Every mode except one-shot reloads the counter on the terminal tick.
    function automatic logic mode_reloads(input mode_t m);
        return m != MODE_ONESHOT;
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Word-indexed CPU peripheral bus: writes land on the clock edge,
// read data is combinational from the address.
interface timer_bank_if #(
    parameter int ADDR_W = 4
);
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;

    modport master (output bus_we, bus_addr, bus_wdata, input bus_rdata);
    modport slave  (input bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/timer_bank_channel.sv
// One timer channel: CTRL/LOAD/CMP registers, down-counter with run FSM,
// pending flag and the registered waveform output.
module timer_bank_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             we_ctrl,
    input  logic             we_load,
    input  logic             we_cmp,
    input  logic [31:0]      wdata,
    output logic [31:0]      ctrl,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] cmp,
    output logic [CNT_W-1:0] cnt,
    output logic             ch_out,
    output logic             irq_req
);

    ch_state_t state;
    mode_t     mode;
    logic      irq_en;
    logic      pending;
    logic      wdata_unused;

    assign wdata_unused = ^{wdata[31:9], wdata[7:4]};

    // Register file, counter FSM and waveform output. The CTRL write is
    // evaluated after the tick logic so it overrides en/mode on a shared edge,
    // while the terminal-tick pending set still beats a same-edge W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CH_IDLE;
            mode    <= MODE_ONESHOT;
            irq_en  <= 1'b0;
            pending <= 1'b0;
            load    <= '0;
            cmp     <= '0;
            cnt     <= '0;
            ch_out  <= 1'b0;
        end else begin
            ch_out <= 1'b0;
            if (we_load) load <= wdata[CNT_W-1:0];
            if (we_cmp)  cmp  <= wdata[CNT_W-1:0];
            if (we_ctrl && wdata[CTRL_PEND]) pending <= 1'b0;

            if (state == CH_RUN) begin
                if (mode == MODE_PWM) ch_out <= (cnt < cmp);
                if (tick) begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        pending <= 1'b1;
                        if (mode != MODE_PWM) ch_out <= 1'b1;
                        if (mode_reloads(mode)) cnt <= load;
                        else                    state <= CH_IDLE;
                    end
                end
            end

            if (we_ctrl) begin
                mode   <= mode_t'(wdata[CTRL_MODE_LSB +: 2]);
                irq_en <= wdata[CTRL_IRQ_EN];
                if (!wdata[CTRL_EN]) begin
                    state <= CH_IDLE;
                end else begin
                    state <= CH_RUN;
                    if (state == CH_IDLE) cnt <= load;
                end
            end
        end
    end

    // CTRL read-back view assembled from the individual fields.
    always_comb begin
        ctrl                         = '0;
        ctrl[CTRL_EN]                = (state == CH_RUN);
        ctrl[CTRL_MODE_LSB +: 2]     = mode;
        ctrl[CTRL_IRQ_EN]            = irq_en;
        ctrl[CTRL_PEND]              = pending;
    end

    assign irq_req = pending & irq_en;

endmodule

// File: rtl/timer_bank.sv
// CH_NUM down-counter timers sharing one prescaler, behind the word-indexed
// peripheral bus. Top level: prescaler, address decode, read mux, irq.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CH_NUM   = 3,
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1,
    localparam int ADDR_W  = $clog2(CH_NUM) + 2
) (
    input  logic              clk,
    input  logic              rst,
    timer_bank_if.slave       bus,
    output logic              irq,
    output logic [CH_NUM-1:0] ch_out
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   presc;
    logic              tick;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    logic [31:0]       rdata;
    logic [CH_NUM-1:0] irq_req;

    logic [31:0]      ctrl_a [CH_NUM];
    logic [CNT_W-1:0] load_a [CH_NUM];
    logic [CNT_W-1:0] cmp_a  [CH_NUM];
    logic [CNT_W-1:0] cnt_a  [CH_NUM];

    assign addr    = bus.bus_addr;
    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];
    assign tick    = (presc == PS_W'(PRESCALE - 1));

    // Free-running prescaler; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PS_W'(1);
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic hit;
        assign hit = bus.bus_we && (ch_sel == ADDR_W'(i));

        timer_bank_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .we_ctrl (hit && reg_sel == REG_CTRL),
            .we_load (hit && reg_sel == REG_LOAD),
            .we_cmp  (hit && reg_sel == REG_CMP),
            .wdata   (bus.bus_wdata),
            .ctrl    (ctrl_a[i]),
            .load    (load_a[i]),
            .cmp     (cmp_a[i]),
            .cnt     (cnt_a[i]),
            .ch_out  (ch_out[i]),
            .irq_req (irq_req[i])
        );
    end

    // Combinational read mux; unmatched channel indices read as zero.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_CTRL: rdata = ctrl_a[i];
                    REG_LOAD: rdata = 32'(load_a[i]);
                    REG_CMP:  rdata = 32'(cmp_a[i]);
                    default:  rdata = 32'(cnt_a[i]);
                endcase
            end
        end
    end

    assign bus.bus_rdata = rdata;

    // Combined interrupt, registered one clock behind the pending flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |irq_req;
    end

endmodule

// File: tb/tb_timer_bank.sv
`timescale 1ns/1ps
// Randomised and directed checks of timer_bank against a closed-form model
// of counter value, pending, enable, waveform output and irq versus clocks
// elapsed since the enabling write.
module tb_timer_bank;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    timer_bank_if #(.ADDR_W(4)) bif ();
    timer_bank_if #(.ADDR_W(4)) bif4 ();

    logic       irq, irq4;
    logic [2:0] ch_out, ch_out4;

    timer_bank #(.CH_NUM(3), .CNT_W(32), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave), .irq(irq), .ch_out(ch_out)
    );

    timer_bank #(.CH_NUM(3), .CNT_W(16), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bif4.slave), .irq(irq4), .ch_out(ch_out4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] addr_of(input int ch, input int r);
        return 4'(ch * 4 + r);
    endfunction

    // Expected counter value n clocks after the enabling edge (PRESCALE=1).
    function automatic int exp_cnt(input int mode, input int ld, input int n);
        if (mode == 0) return (n >= ld) ? 0 : ld - n;
        return ld - (n % (ld + 1));
    endfunction

    // Expected waveform output n clocks after the enabling edge.
    function automatic bit exp_out(input int mode, input int ld, input int cmpv, input int n);
        if (n < 1) return 1'b0;
        if (mode == 0) return n == ld + 1;
        if (mode == 2) return (ld - ((n - 1) % (ld + 1))) < cmpv;
        return (n % (ld + 1)) == 0;
    endfunction

    task automatic bus_write(input bit sel4, input logic [3:0] a, input logic [31:0] d);
        if (sel4) begin
            bif4.bus_we = 1'b1; bif4.bus_addr = a; bif4.bus_wdata = d;
        end else begin
            bif.bus_we = 1'b1; bif.bus_addr = a; bif.bus_wdata = d;
        end
        @(negedge clk);
        bif.bus_we  = 1'b0;
        bif4.bus_we = 1'b0;
    endtask

    task automatic bus_read(input bit sel4, input logic [3:0] a, output logic [31:0] d);
        if (sel4) begin
            bif4.bus_addr = a; #1; d = bif4.bus_rdata;
        end else begin
            bif.bus_addr = a; #1; d = bif.bus_rdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Program one channel of the PRESCALE=1 instance, enable it and compare
    // ncyc consecutive clocks against the model; returns at n = ncyc.
    task automatic run_check(input int ch, input int mode, input int ld, input int cmpv,
                             input int ien, input int ncyc);
        logic [31:0] rd;
        logic [2:0]  ev;
        bus_write(1'b0, addr_of(ch, 1), 32'(ld));
        bus_write(1'b0, addr_of(ch, 2), 32'(cmpv));
        bus_write(1'b0, addr_of(ch, 0), 32'(1 | (mode << 1) | (ien << 3)));
        for (int n = 0; n < ncyc; n++) begin
            bus_read(1'b0, addr_of(ch, 3), rd);
            check_eq($sformatf("c%0d m%0d L%0d cnt n=%0d", ch, mode, ld, n), rd, 32'(exp_cnt(mode, ld, n)));
            bus_read(1'b0, addr_of(ch, 0), rd);
            check_eq($sformatf("c%0d m%0d L%0d pend n=%0d", ch, mode, ld, n), 32'(rd[8]), 32'(n >= ld + 1));
            check_eq($sformatf("c%0d m%0d L%0d en n=%0d", ch, mode, ld, n), 32'(rd[0]),
                     32'((mode != 0) || (n < ld + 1)));
            ev = 3'(exp_out(mode, ld, cmpv, n)) << ch;
            check_eq($sformatf("c%0d m%0d L%0d C%0d ch_out n=%0d", ch, mode, ld, cmpv, n), 32'(ch_out), 32'(ev));
            check_eq($sformatf("c%0d m%0d L%0d irq n=%0d", ch, mode, ld, n), 32'(irq),
                     32'((ien != 0) && (n >= ld + 2)));
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int highs, j, ticks;
        bit pend_exp, irq_exp;

        rst = 1'b1;
        bif.bus_we = 1'b0;  bif.bus_addr = '0;  bif.bus_wdata = '0;
        bif4.bus_we = 1'b0; bif4.bus_addr = '0; bif4.bus_wdata = '0;

        // Reset state
        #5;
        for (int a = 0; a < 12; a++) begin
            bus_read(1'b0, 4'(a), rd);
            check_eq($sformatf("reset rdata a=%0d", a), rd, 32'h0);
        end
        check_eq("reset irq", 32'(irq), 32'h0);
        check_eq("reset ch_out", 32'(ch_out), 32'h0);
        do_reset();

        // One-shot, periodic with LOAD=0
        run_check(0, 0, 5, 0, 1, 12);
        do_reset();
        run_check(0, 1, 0, 0, 1, 6);
        do_reset();

        // Periodic with W1C on terminal and non-terminal edges
        run_check(1, 1, 3, 0, 1, 11);
        bus_write(1'b0, addr_of(1, 0), 32'h10B);
        bus_read(1'b0, addr_of(1, 0), rd);
        check_eq("w1c terminal pend", 32'(rd[8]), 32'h1);
        check_eq("w1c terminal ch_out", 32'(ch_out), 32'h2);
        bus_write(1'b0, addr_of(1, 0), 32'h10B);
        bus_read(1'b0, addr_of(1, 0), rd);
        check_eq("w1c plain pend", 32'(rd[8]), 32'h0);
        bus_read(1'b0, addr_of(1, 3), rd);
        check_eq("w1c cnt undisturbed", rd, 32'h2);
        repeat (3) @(negedge clk);
        bus_read(1'b0, addr_of(1, 0), rd);
        check_eq("pend re-set", 32'(rd[8]), 32'h1);
        do_reset();

        // PWM duty, then CMP extremes
        run_check(2, 2, 9, 3, 0, 25);
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            highs += int'(ch_out[2]);
            @(negedge clk);
        end
        check_eq("pwm highs per period", 32'(highs), 32'd3);
        check_eq("pwm irq", 32'(irq), 32'h0);
        bus_write(1'b0, addr_of(2, 2), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("pwm cmp0 k=%0d", k), 32'(ch_out[2]), 32'h0);
            @(negedge clk);
        end
        bus_write(1'b0, addr_of(2, 2), 32'd12);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("pwm cmp12 k=%0d", k), 32'(ch_out[2]), 32'h1);
            @(negedge clk);
        end
        do_reset();

        // Out-of-range channel and read-only CNT
        bus_write(1'b0, addr_of(0, 1), 32'h11);
        bus_write(1'b0, addr_of(1, 1), 32'h22);
        bus_write(1'b0, addr_of(2, 1), 32'h33);
        bus_write(1'b0, addr_of(3, 1), 32'hFFFF);
        bus_read(1'b0, addr_of(3, 1), rd);
        check_eq("ch3 load read", rd, 32'h0);
        for (int c = 0; c < 3; c++) begin
            bus_read(1'b0, addr_of(c, 1), rd);
            check_eq($sformatf("load ch%0d kept", c), rd, 32'(17 * (c + 1)));
        end
        bus_write(1'b0, addr_of(0, 3), 32'h55);
        bus_read(1'b0, addr_of(0, 3), rd);
        check_eq("cnt write ignored", rd, 32'h0);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            int ch, mode, ld, cmpv, ien;
            do_reset();
            ch   = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 3));
            ld   = int'($urandom_range(0, 6));
            cmpv = int'($urandom_range(0, 8));
            ien  = int'($urandom_range(0, 1));
            run_check(ch, mode, ld, cmpv, ien, 2 * (ld + 1) + 3 + int'($urandom_range(0, 4)));
        end

        // PRESCALE=4, CNT_W=16 instance
        do_reset();
        j = 0;
        bus_write(1'b1, addr_of(0, 1), 32'h12345); j++;
        bus_read(1'b1, addr_of(0, 1), rd);
        check_eq("w16 load trunc", rd, 32'h2345);
        bus_write(1'b1, addr_of(0, 2), 32'hFFFF_FFFF); j++;
        bus_read(1'b1, addr_of(0, 2), rd);
        check_eq("w16 cmp trunc", rd, 32'hFFFF);
        bus_write(1'b1, addr_of(0, 1), 32'd2); j++;
        bus_write(1'b1, addr_of(0, 0), 32'h9); j++;
        ticks = 0;
        irq_exp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pend_exp = (ticks >= 3);
            bus_read(1'b1, addr_of(0, 3), rd);
            check_eq($sformatf("ps4 cnt j=%0d", j), rd, 32'((ticks >= 2) ? 0 : 2 - ticks));
            bus_read(1'b1, addr_of(0, 0), rd);
            check_eq($sformatf("ps4 pend j=%0d", j), 32'(rd[8]), 32'(pend_exp));
            check_eq($sformatf("ps4 irq j=%0d", j), 32'(irq4), 32'(irq_exp));
            @(negedge clk);
            j++;
            irq_exp = pend_exp;
            if (j % 4 == 0) ticks++;
        end

        // Asynchronous reset mid-run, then silence
        bus_write(1'b1, addr_of(1, 1), 32'd1);
        bus_write(1'b1, addr_of(1, 0), 32'hB);
        bus_write(1'b0, addr_of(0, 1), 32'd1);
        bus_write(1'b0, addr_of(0, 0), 32'hB);
        repeat (16) @(negedge clk);
        check_eq("pre-rst irq4", 32'(irq4), 32'h1);
        check_eq("pre-rst irq", 32'(irq), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async rst irq4", 32'(irq4), 32'h0);
        check_eq("async rst irq", 32'(irq), 32'h0);
        check_eq("async rst ch_out4", 32'(ch_out4), 32'h0);
        check_eq("async rst ch_out", 32'(ch_out), 32'h0);
        bus_read(1'b1, addr_of(1, 0), rd);
        check_eq("async rst ctrl4", rd, 32'h0);
        bus_read(1'b1, addr_of(1, 3), rd);
        check_eq("async rst cnt4", rd, 32'h0);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check_eq($sformatf("post-rst out k=%0d", k), 32'({ch_out4, ch_out, irq4, irq}), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
